// File: rtl/fdivsqrt_iter_ctrl_pkg.sv
// Shared types and constants for the radix-2 divide/sqrt iteration controller.
// Default sizing comes from the divider configuration record.
package fdivsqrt_iter_ctrl_pkg;

  typedef struct packed {
    int unsigned DIVB;
    int unsigned CNTW;
  } divsqrt_cfg_t;

  localparam divsqrt_cfg_t DIVSQRT_CFG = '{DIVB: 56, CNTW: 6};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } divsqrt_state_e;

  // Upper bits of C at operation start; the remaining DIVB bits start cleared.
  localparam logic [1:0] C_INIT_HI = 2'b11;

endpackage

// File: rtl/fdivsqrt_iter_cnt.sv
// Loadable down-counter with zero flag; it saturates at zero and never wraps.
module fdivsqrt_iter_cnt #(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            dec_i,
  input  logic [CNTW-1:0] load_val_i,
  output logic            zero_o
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && !zero_o)
      cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration controller for the radix-2 divide/sqrt datapath: sequences init,
// iterations with early termination, and result hand-off; owns the C mask.
//
// state | meaning
// IDLE  | ready for a new operation
// BUSY  | datapath iterating, one quotient/root bit per cycle
// DONE  | result valid, waiting for downstream to take it
module fdivsqrt_iter_ctrl
  import fdivsqrt_iter_ctrl_pkg::*;
#(
  parameter int DIVB = int'(DIVSQRT_CFG.DIVB),
  parameter int CNTW = int'(DIVSQRT_CFG.CNTW)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic            SqrtE,
  input  logic            SpecialCaseE,
  input  logic [CNTW-1:0] Cycles,
  input  logic            WZeroE,
  input  logic            StallM,
  output logic            ReadyE,
  output logic            BusyE,
  output logic            IterEn,
  output logic            InitE,
  output logic [DIVB+1:0] C,
  output logic            SqrtOp,
  output logic            DoneM
);

  divsqrt_state_e  state_q, state_d;
  logic [DIVB+1:0] c_q, c_d;
  logic            sqrt_q, sqrt_d;
  logic            accept;
  logic            iter_active;
  logic            cnt_zero;

  // Flush and reset both block acceptance so a coincident StartE is dropped.
  assign accept      = (state_q == ST_IDLE) && StartE && !FlushE && !reset;
  assign iter_active = (state_q == ST_BUSY) && !FlushE && !reset;

  fdivsqrt_iter_cnt #(.CNTW(CNTW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .dec_i      (iter_active),
    .load_val_i (Cycles - CNTW'(1)),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (FlushE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (StartE) state_d = SpecialCaseE ? ST_DONE : ST_BUSY;
        ST_BUSY: if (cnt_zero || WZeroE) state_d = ST_DONE;
        ST_DONE: if (!StallM) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ReadyE = (state_q == ST_IDLE) && !FlushE;
    BusyE  = (state_q != ST_IDLE);
    DoneM  = (state_q == ST_DONE);
    InitE  = accept;
    IterEn = iter_active;
  end

  // Each iteration shifts in one more ones bit from the top.
  always_comb begin
    c_d    = c_q;
    sqrt_d = sqrt_q;
    if (accept) begin
      c_d    = {C_INIT_HI, {DIVB{1'b0}}};
      sqrt_d = SqrtE;
    end else if (iter_active) begin
      c_d = {1'b1, c_q[DIVB+1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      sqrt_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      sqrt_q <= sqrt_d;
    end
  end

  assign C      = c_q;
  assign SqrtOp = sqrt_q;

endmodule
